magic_cfg_loader: RTL and testbench

// - Boot-time initiator for the magic config register file (CPU port 0x??FF, index in A[15:8]).
// - After reset, reads a saved settings record from an external SPI EEPROM, validates it, and replays it as config writes.
// - Sits beside the magic config block; top level ORs cfg_wr/cfg_idx/cfg_data with the CPU-side write path and holds the CPU while busy.

---
 rtl/magic_cfg_loader_pkg.sv | 17 +
 rtl/magic_cfg_loader_spi_shift8.sv | 85 ++++++++
 rtl/magic_cfg_loader.sv | 192 +++++++++++++++++++
 tb/tb_magic_cfg_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/magic_cfg_loader_pkg.sv
// Shared types and constants for the boot-time config loader.
package magic_cfg_loader_pkg;

    typedef enum logic [2:0] {
        LD_WAIT,
        LD_CMD,
        LD_READ,
        LD_CHECK,
        LD_REPLAY,
        LD_DONE,
        LD_FAIL
    } loader_state_t;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] CFG_IDX_FIRST = 8'h01;

endpackage

// File: rtl/magic_cfg_loader_spi_shift8.sv
// SPI mode-0 byte engine: SCK divider plus 8-bit shift register with start/done handshake.
module magic_cfg_loader_spi_shift8 #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          active_q, active_d;
    logic [DW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          half_end;

    always_comb begin
        half_end = active_q && (div_q == DW'(CLK_DIV - 1));
        done     = half_end && sck_q && (bit_q == 3'd7);
        active_d = active_q;
        div_d    = div_q;
        sck_d    = sck_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        // A start coinciding with done chains bytes with no gap in SCK.
        if (start && (!active_q || done)) begin
            active_d = 1'b1;
            div_d    = '0;
            sck_d    = 1'b0;
            bit_d    = 3'd0;
            tx_d     = tx_byte;
        end else if (active_q) begin
            if (half_end) begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[6:0], miso};
                end else begin
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = {tx_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            sck_q    <= 1'b0;
            bit_q    <= 3'd0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            sck_q    <= sck_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    assign sck     = sck_q;
    assign mosi    = active_q & tx_q[7];
    assign rx_byte = rx_q;

endmodule

// File: rtl/magic_cfg_loader.sv
// Boot-time loader: reads a checksummed settings record from SPI EEPROM and replays it as
// config register writes, all-or-nothing.
module magic_cfg_loader
    import magic_cfg_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter logic [23:0] REC_ADDR    = 24'h000000,
    parameter logic [7:0]  REC_SIG     = 8'hA5,
    parameter int unsigned NREG        = 11,
    parameter int unsigned START_DELAY = 1024
) (
    input  logic       clk28,
    input  logic       rst_n,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       cfg_wr,
    output logic [7:0] cfg_idx,
    output logic [7:0] cfg_data,
    output logic       busy,
    output logic       ok,
    output logic       fail
);

    localparam int unsigned CMAX = (START_DELAY > CLK_DIV) ? START_DELAY : CLK_DIV;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned BW   = $clog2(NREG + 4);

    loader_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] byte_q, byte_d;
    logic          tail_q, tail_d;
    logic          gap_q, gap_d;
    logic          cs_n_q, cs_n_d;
    logic [7:0]    sig_q, sig_d;
    logic [7:0]    sum_q, sum_d;
    logic          cfg_wr_q, cfg_wr_d;
    logic [7:0]    cfg_idx_q, cfg_idx_d;
    logic [7:0]    cfg_data_q, cfg_data_d;
    logic [7:0]    payload_q [NREG];
    logic          pl_we;
    logic [BW-1:0] pl_idx;

    logic          sh_start, sh_done;
    logic [7:0]    sh_tx, sh_rx;
    logic [7:0]    cmd_bytes [4];

    assign cmd_bytes = '{SPI_CMD_READ, REC_ADDR[23:16], REC_ADDR[15:8], REC_ADDR[7:0]};

    magic_cfg_loader_spi_shift8 #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk28   (clk28),
        .rst_n   (rst_n),
        .start   (sh_start),
        .tx_byte (sh_tx),
        .miso    (spi_miso),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .done    (sh_done),
        .rx_byte (sh_rx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        tail_d     = tail_q;
        gap_d      = gap_q;
        cs_n_d     = cs_n_q;
        sig_d      = sig_q;
        sum_d      = sum_q;
        cfg_wr_d   = 1'b0;
        cfg_idx_d  = cfg_idx_q;
        cfg_data_d = cfg_data_q;
        sh_start   = 1'b0;
        sh_tx      = 8'h00;
        pl_we      = 1'b0;
        pl_idx     = byte_q - BW'(1);
        unique case (state_q)
            LD_WAIT: begin
                if (cnt_q == CW'(START_DELAY - 1)) begin
                    cs_n_d   = 1'b0;
                    sh_start = 1'b1;
                    sh_tx    = cmd_bytes[0];
                    byte_d   = '0;
                    state_d  = LD_CMD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LD_CMD: begin
                if (sh_done) begin
                    sh_start = 1'b1;
                    if (byte_q == BW'(3)) begin
                        byte_d  = '0;
                        state_d = LD_READ;
                    end else begin
                        sh_tx  = cmd_bytes[2'(byte_q + BW'(1))];
                        byte_d = byte_q + BW'(1);
                    end
                end
            end
            LD_READ: begin
                // tail_q: last bit shifted, hold CS for one more SCK half-period
                if (tail_q) begin
                    if (cnt_q == CW'(CLK_DIV - 1)) begin
                        cs_n_d  = 1'b1;
                        tail_d  = 1'b0;
                        state_d = LD_CHECK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (sh_done) begin
                    sum_d = sum_q + sh_rx;
                    if (byte_q == '0) sig_d = sh_rx;
                    if (byte_q != '0 && byte_q <= BW'(NREG)) pl_we = 1'b1;
                    if (byte_q == BW'(NREG + 1)) begin
                        tail_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        byte_d   = byte_q + BW'(1);
                        sh_start = 1'b1;
                    end
                end
            end
            LD_CHECK: begin
                if (sig_q == REC_SIG && sig_q != 8'hFF && sum_q == 8'h00) begin
                    byte_d  = '0;
                    gap_d   = 1'b0;
                    state_d = LD_REPLAY;
                end else begin
                    state_d = LD_FAIL;
                end
            end
            LD_REPLAY: begin
                if (gap_q) begin
                    gap_d  = 1'b0;
                    byte_d = byte_q + BW'(1);
                end else begin
                    cfg_wr_d   = 1'b1;
                    cfg_idx_d  = CFG_IDX_FIRST + 8'(byte_q);
                    cfg_data_d = payload_q[byte_q];
                    if (byte_q == BW'(NREG - 1)) state_d = LD_DONE;
                    else gap_d = 1'b1;
                end
            end
            LD_DONE, LD_FAIL: ;
            default: state_d = LD_WAIT;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LD_WAIT;
            cnt_q      <= '0;
            byte_q     <= '0;
            tail_q     <= 1'b0;
            gap_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            sig_q      <= 8'h00;
            sum_q      <= 8'h00;
            cfg_wr_q   <= 1'b0;
            cfg_idx_q  <= 8'h00;
            cfg_data_q <= 8'h00;
            for (int i = 0; i < NREG; i++) payload_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            tail_q     <= tail_d;
            gap_q      <= gap_d;
            cs_n_q     <= cs_n_d;
            sig_q      <= sig_d;
            sum_q      <= sum_d;
            cfg_wr_q   <= cfg_wr_d;
            cfg_idx_q  <= cfg_idx_d;
            cfg_data_q <= cfg_data_d;
            if (pl_we) payload_q[pl_idx] <= sh_rx;
        end
    end

    assign spi_cs_n = cs_n_q;
    assign cfg_wr   = cfg_wr_q;
    assign cfg_idx  = cfg_idx_q;
    assign cfg_data = cfg_data_q;
    assign ok       = (state_q == LD_DONE);
    assign fail     = (state_q == LD_FAIL);
    assign busy     = !(ok || fail);

endmodule

// File: tb/tb_magic_cfg_loader.sv
// Bench for magic_cfg_loader: SPI EEPROM model plus record-level reference of expected writes.
module tb_magic_cfg_loader;

    localparam int unsigned CLK_DIV     = 4;
    localparam logic [23:0] REC_ADDR    = 24'h000000;
    localparam logic [7:0]  REC_SIG     = 8'hA5;
    localparam int unsigned NREG        = 11;
    localparam int unsigned START_DELAY = 1024;
    localparam int unsigned XFER_CYC    = (32 + 8 * (NREG + 2)) * 2 * CLK_DIV;
    // CS release half-period after the last bit, one CHECK cycle, registered strobe
    localparam int unsigned OVERHEAD    = CLK_DIV + 2;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_cs_n, spi_sck, spi_mosi;
    logic       spi_miso = 1'b0;
    logic       cfg_wr, busy, ok, fail;
    logic [7:0] cfg_idx, cfg_data;

    always #5 clk28 = ~clk28;

    magic_cfg_loader #(
        .CLK_DIV     (CLK_DIV),
        .REC_ADDR    (REC_ADDR),
        .REC_SIG     (REC_SIG),
        .NREG        (NREG),
        .START_DELAY (START_DELAY)
    ) dut (
        .clk28    (clk28),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .cfg_wr   (cfg_wr),
        .cfg_idx  (cfg_idx),
        .cfg_data (cfg_data),
        .busy     (busy),
        .ok       (ok),
        .fail     (fail)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // EEPROM contents and observation state
    logic [7:0]  rec [NREG + 2];
    bit          blank = 1'b0;
    int unsigned rise_cnt = 0;
    logic [31:0] cmd_bits = '0;
    logic        mosi_rise = 1'b0;
    bit          first_rise = 1'b1;
    int unsigned last_rise = 0;
    int unsigned cyc = 0;
    int unsigned sck_bad = 0, mosi_bad = 0, both_cnt = 0;
    int unsigned s_cyc [$];
    logic [7:0]  s_idx [$];
    logic [7:0]  s_data [$];

    always @(posedge clk28) cyc = rst_n ? cyc + 1 : 0;

    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            rise_cnt   = 0;
            first_rise = 1'b1;
        end else begin
            if (rise_cnt < 32) cmd_bits = {cmd_bits[30:0], spi_mosi};
            mosi_rise = spi_mosi;
            if (!first_rise && (cyc - last_rise) != 2 * CLK_DIV) sck_bad++;
            first_rise = 1'b0;
            last_rise  = cyc;
            rise_cnt++;
        end
    end

    always @(negedge spi_sck or negedge spi_cs_n) begin
        int unsigned b;
        logic [7:0]  byte_v;
        if (blank) begin
            spi_miso = 1'b1;
        end else if (!spi_cs_n && rise_cnt >= 32) begin
            b = rise_cnt - 32;
            if (b < 8 * (NREG + 2)) begin
                byte_v   = rec[b / 8];
                spi_miso = byte_v[7 - (b % 8)];
            end else begin
                spi_miso = 1'b1;
            end
        end else begin
            spi_miso = 1'b0;
        end
    end

    always @(negedge clk28) begin
        if (rst_n && cfg_wr) begin
            s_cyc.push_back(cyc);
            s_idx.push_back(cfg_idx);
            s_data.push_back(cfg_data);
        end
        if (ok && fail) both_cnt++;
        if (rst_n && !spi_cs_n && spi_sck && spi_mosi !== mosi_rise) mosi_bad++;
    end

    task automatic do_reset(input string name);
        @(negedge clk28);
        rst_n = 1'b0;
        repeat (3) @(negedge clk28);
        check({name, "_reset_outs"},
              {spi_cs_n, spi_sck, spi_mosi, cfg_wr, cfg_idx, cfg_data, busy, ok, fail},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic release_reset();
        @(negedge clk28);
        rst_n = 1'b1;
    endtask

    task automatic run_case(input string name, input bit do_abort);
        logic [7:0]  sum;
        bit          exp_ok, timed_out;
        int unsigned base, nstr, mb, sb, bc;
        sum = 8'h00;
        for (int i = 0; i < NREG + 2; i++) sum += rec[i];
        exp_ok = !blank && rec[0] == REC_SIG && sum == 8'h00;

        do_reset(name);
        if (do_abort) begin
            release_reset();
            timed_out = 1'b1;
            for (int i = 0; i < START_DELAY + XFER_CYC; i++) begin
                @(negedge clk28);
                if (rise_cnt >= 32 + 5 * 8 + 3) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            check({name, "_abort_point"}, 32'(timed_out), 32'd0);
            do_reset({name, "_abort"});
        end
        mb   = mosi_bad;
        sb   = sck_bad;
        bc   = both_cnt;
        base = s_cyc.size();
        release_reset();

        timed_out = 1'b1;
        for (int i = 0; i < START_DELAY + XFER_CYC + 200; i++) begin
            @(negedge clk28);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        check({name, "_finish"}, 32'(timed_out), 32'd0);
        repeat (20) @(negedge clk28);

        check({name, "_ok"}, 32'(ok), 32'(exp_ok));
        check({name, "_fail"}, 32'(fail), 32'(!exp_ok));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_cs_idle"}, 32'(spi_cs_n), 32'd1);
        check({name, "_cmd"}, cmd_bits, {8'h03, REC_ADDR});
        check({name, "_mosi_stable"}, mosi_bad - mb, 32'd0);
        check({name, "_sck_period"}, sck_bad - sb, 32'd0);
        check({name, "_ok_and_fail"}, both_cnt - bc, 32'd0);

        nstr = s_cyc.size() - base;
        check({name, "_n_strobes"}, nstr, exp_ok ? NREG : 0);
        for (int k = 0; k < int'(nstr) && k < int'(NREG); k++) begin
            check($sformatf("%s_idx%0d", name, k), 32'(s_idx[base + k]), 32'(k + 1));
            check($sformatf("%s_data%0d", name, k), 32'(s_data[base + k]), 32'(rec[k + 1]));
            if (k == 0)
                check({name, "_first_strobe_cyc"}, s_cyc[base],
                      START_DELAY + XFER_CYC + OVERHEAD);
            else
                check($sformatf("%s_gap%0d", name, k), s_cyc[base + k] - s_cyc[base + k - 1], 2);
        end
    endtask

    task automatic set_csum();
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i <= NREG; i++) sum += rec[i];
        rec[NREG + 1] = 8'h00 - sum;
    endtask

    task automatic fill_random(input bit corrupt);
        int unsigned p;
        logic [7:0]  v;
        rec[0] = REC_SIG;
        for (int i = 1; i <= NREG; i++) rec[i] = 8'($urandom);
        set_csum();
        if (corrupt) begin
            p      = $urandom_range(0, NREG + 1);
            v      = rec[p];
            v[$urandom_range(0, 7)] = ~v[$urandom_range(0, 7)] ^ 1'b0;
            v      = rec[p] ^ (8'h01 << $urandom_range(0, 7));
            rec[p] = v;
        end
    endtask

    initial begin
        logic [7:0] fixed [NREG + 1];
        fixed = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03,
                  8'h01};
        for (int i = 0; i <= NREG; i++) rec[i] = fixed[i];
        set_csum();
        run_case("good", 1'b0);

        rec[NREG + 1] = rec[NREG + 1] + 8'h01;
        run_case("bad_csum", 1'b0);

        blank = 1'b1;
        for (int i = 0; i < NREG + 2; i++) rec[i] = 8'hFF;
        run_case("blank", 1'b0);
        blank = 1'b0;

        for (int i = 0; i <= NREG; i++) rec[i] = fixed[i];
        set_csum();
        run_case("abort", 1'b1);

        for (int t = 0; t < 4; t++) begin
            fill_random($urandom_range(0, 2) == 2);
            run_case($sformatf("rand%0d", t), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
